// File: rtl/rv32im_exu_ctrl_pkg.sv
// rv32im_exu_ctrl_pkg: opcode encodings, controller state encoding and defaults shared across the EXU
package rv32im_exu_ctrl_pkg;
  localparam int API_DATA_WIDTH = 32;
  localparam int ALU_OPCODE_WIDTH = 5;
  localparam int LSU_OPCODE_WIDTH = 4;
  localparam int EXU_CTRL_ST_WIDTH = 3;
  localparam int EXU_CTRL_DIV_CYCLES = 32;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_NONE = 5'd0;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_ADD = 5'd1;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SUB = 5'd2;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SLL = 5'd3;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SLT = 5'd4;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SLTU = 5'd5;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_XOR = 5'd6;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SRL = 5'd7;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_SRA = 5'd8;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_OR = 5'd9;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_AND = 5'd10;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_MUL = 5'd11;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_MULH = 5'd12;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_MULHSU = 5'd13;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_MULHU = 5'd14;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_DIV = 5'd15;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_DIVU = 5'd16;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_REM = 5'd17;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OPCODE_REMU = 5'd18;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_NONE = 4'd0;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LB = 4'd1;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LH = 4'd2;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LW = 4'd3;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LBU = 4'd4;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LHU = 4'd5;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SB = 4'd6;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SH = 4'd7;
  localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SW = 4'd8;
  typedef enum logic [EXU_CTRL_ST_WIDTH-1:0] {
    EXU_CTRL_ST_IDLE,
    EXU_CTRL_ST_EXEC,
    EXU_CTRL_ST_DIV,
    EXU_CTRL_ST_MEM_REQ,
    EXU_CTRL_ST_MEM_WAIT,
    EXU_CTRL_ST_COMMIT
  } exu_ctrl_st_e;
  function automatic logic is_div_op(input logic [ALU_OPCODE_WIDTH-1:0] op);
    return op inside {ALU_OPCODE_DIV, ALU_OPCODE_DIVU, ALU_OPCODE_REM, ALU_OPCODE_REMU};
  endfunction
  function automatic logic is_store_op(input logic [LSU_OPCODE_WIDTH-1:0] op);
    return op inside {LSU_OPCODE_SB, LSU_OPCODE_SH, LSU_OPCODE_SW};
  endfunction
endpackage

// File: rtl/rv32im_exu_ctrl.sv
// rv32im_exu_ctrl: sequences one decoded instruction through ALU, divide or memory phases to a single commit
module rv32im_exu_ctrl
  import rv32im_exu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = API_DATA_WIDTH,
  parameter int DIV_CYCLES = EXU_CTRL_DIV_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [ALU_OPCODE_WIDTH-1:0] alu_opcode_i,
  input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic                        is_branch_i,
  input  logic                        flush_i,
  input  logic [DATA_WIDTH-1:0]       exu_data_i,
  input  logic [DATA_WIDTH-1:0]       exu_new_pc_i,
  output logic                        muldiv_step_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  output logic                        done_o,
  output logic                        wb_we_o,
  output logic [DATA_WIDTH-1:0]       wb_data_o,
  output logic                        pc_we_o,
  output logic [DATA_WIDTH-1:0]       pc_o,
  output logic                        busy_o
);
  exu_ctrl_st_e state_q, state_d;
  logic [ALU_OPCODE_WIDTH-1:0] alu_op_q;
  logic [LSU_OPCODE_WIDTH-1:0] lsu_op_q;
  logic [7:0] cnt_q, cnt_d;
  logic is_branch_q, drop_q, drop_d, cap_data, cap_pc, transfer, is_store, wb_en, drop_now;
  assign issue_ready_o = rst_n_i && state_q == EXU_CTRL_ST_IDLE && !flush_i;
  assign transfer = issue_valid_i && issue_ready_o;
  assign is_store = is_store_op(lsu_op_q);
  assign wb_en = !is_store && !(is_branch_q && alu_op_q == ALU_OPCODE_NONE);
  assign drop_now = drop_q || flush_i;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drop_d = drop_q;
    cap_data = 1'b0;
    cap_pc = 1'b0;
    case (state_q)
      EXU_CTRL_ST_IDLE: begin
        drop_d = 1'b0;
        state_d = transfer ? EXU_CTRL_ST_EXEC : EXU_CTRL_ST_IDLE;
      end
      EXU_CTRL_ST_EXEC: begin
        if (flush_i) state_d = EXU_CTRL_ST_IDLE;
        else if (lsu_op_q != LSU_OPCODE_NONE) state_d = EXU_CTRL_ST_MEM_REQ;
        else if (is_div_op(alu_op_q)) begin
          cnt_d = 8'(DIV_CYCLES - 1);
          state_d = EXU_CTRL_ST_DIV;
        end else begin
          cap_data = 1'b1;
          cap_pc = 1'b1;
          state_d = EXU_CTRL_ST_COMMIT;
        end
      end
      EXU_CTRL_ST_DIV: begin
        if (flush_i) state_d = EXU_CTRL_ST_IDLE;
        else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          cap_data = 1'b1;
          cap_pc = 1'b1;
          state_d = EXU_CTRL_ST_COMMIT;
        end
      end
      EXU_CTRL_ST_MEM_REQ: begin
        if (mem_gnt_i) begin
          drop_d = flush_i;
          state_d = !is_store ? EXU_CTRL_ST_MEM_WAIT : flush_i ? EXU_CTRL_ST_IDLE : EXU_CTRL_ST_COMMIT;
        end else if (flush_i) state_d = EXU_CTRL_ST_IDLE;
      end
      EXU_CTRL_ST_MEM_WAIT: begin
        drop_d = drop_now;
        if (mem_rvalid_i) begin
          cap_data = !drop_now;
          state_d = drop_now ? EXU_CTRL_ST_IDLE : EXU_CTRL_ST_COMMIT;
        end
      end
      EXU_CTRL_ST_COMMIT: state_d = EXU_CTRL_ST_IDLE;
      default: state_d = EXU_CTRL_ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= EXU_CTRL_ST_IDLE;
      alu_op_q <= ALU_OPCODE_NONE;
      lsu_op_q <= LSU_OPCODE_NONE;
      is_branch_q <= 1'b0;
      cnt_q <= 8'd0;
      drop_q <= 1'b0;
      muldiv_step_o <= 1'b0;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      done_o <= 1'b0;
      wb_we_o <= 1'b0;
      pc_we_o <= 1'b0;
      busy_o <= 1'b0;
      wb_data_o <= '0;
      pc_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      if (transfer) begin
        alu_op_q <= alu_opcode_i;
        lsu_op_q <= lsu_opcode_i;
        is_branch_q <= is_branch_i;
      end
      if (cap_data) wb_data_o <= exu_data_i;
      if (cap_pc) pc_o <= exu_new_pc_i;
      muldiv_step_o <= state_d == EXU_CTRL_ST_DIV;
      mem_req_o <= state_d == EXU_CTRL_ST_MEM_REQ;
      mem_we_o <= state_d == EXU_CTRL_ST_MEM_REQ && is_store;
      done_o <= state_d == EXU_CTRL_ST_COMMIT;
      wb_we_o <= state_d == EXU_CTRL_ST_COMMIT && wb_en;
      pc_we_o <= state_d == EXU_CTRL_ST_COMMIT && is_branch_q;
      busy_o <= state_d != EXU_CTRL_ST_IDLE;
    end
  end
endmodule
